// File: rtl/apb_slave_regs_if.sv
`default_nettype none
// ============================================================================
//  Module   : apb_slave_regs_if
//  Purpose  : APB3 bus signal bundle between a requester and the
//             apb_slave_regs completer.
//  Ports    : none. The clock and reset stay outside the bundle as scalar
//             ports of the modules that use it.
//  Signals  : PSEL, PENABLE, PWRITE, PADDR[ADDR_W], PWDATA[DATA_W]
//               are driven by the requester.
//             PRDATA[DATA_W], PREADY, PSLVERR
//               are driven by the completer.
//  Revision : 1.0  initial release
// ============================================================================
interface apb_slave_regs_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  // Requester (master) view of the bus.
  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  // Completer (slave) view of the bus.
  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface : apb_slave_regs_if
`default_nettype wire

// File: rtl/apb_slave_regs.sv
`default_nettype none
// ============================================================================
//  Module   : apb_slave_regs
//  Purpose  : APB3 completer that holds four 32-bit registers. It inserts a
//             programmable number of wait states and signals decode errors
//             through PSLVERR.
//
//  Register map (byte address, full decode):
//    0x0 CTRL    RW  [3:0] WAIT = access-phase wait states; [31:4] read 0
//    0x4 SCRATCH RW  32-bit general purpose
//    0x8 ID      RO  returns ID_VALUE; a write is an error
//    0xC WR_CNT  RW  counts good writes to CTRL/SCRATCH; any write clears it
//    Any other address is an error: reads return 0 and writes are dropped.
//
//  Ports    : PCLK      in   bus clock, rising-edge active
//             PRESETn   in   asynchronous active-low reset
//             bus       slave modport of apb_slave_regs_if
//                         (PSEL/PENABLE/PWRITE/PADDR/PWDATA in,
//                          PRDATA/PREADY/PSLVERR out)
//  Revision : 1.0  initial release
// ============================================================================
module apb_slave_regs #(
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter logic [31:0]     ID_VALUE = 32'hA9B0_0001
) (
  input  wire                PCLK,
  input  wire                PRESETn,
  apb_slave_regs_if.slave    bus
);

  // --------------------------------------------------------------------------
  // Elaboration checks
  // --------------------------------------------------------------------------
  if (DATA_W != 32) begin : g_bad_data_w
    $error("apb_slave_regs: DATA_W must be 32");
  end

  if (ADDR_W < 4) begin : g_bad_addr_w
    $error("apb_slave_regs: ADDR_W must be at least 4");
  end

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0] c_IDX_CTRL    = 2'd0;
  localparam logic [1:0] c_IDX_SCRATCH = 2'd1;
  localparam logic [1:0] c_IDX_ID      = 2'd2;
  localparam logic [1:0] c_IDX_WR_CNT  = 2'd3;

  localparam logic [DATA_W-1:0] c_ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t            state_q,     state_d;
  logic [3:0]        wcnt_q,      wcnt_d;
  logic [3:0]        ctrl_wait_q, ctrl_wait_d;
  logic [DATA_W-1:0] scratch_q,   scratch_d;
  logic [DATA_W-1:0] wr_cnt_q,    wr_cnt_d;

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  logic       w_upper_zero;
  logic       w_addr_ok;
  logic [1:0] w_idx;
  logic       w_decode_err;

  // Any set bit above the 16-byte window makes the access an error. When the
  // bus is exactly 4 bits wide there are no upper bits to check.
  if (ADDR_W > 4) begin : g_upper_chk
    assign w_upper_zero = (bus.PADDR[ADDR_W-1:4] == '0);
  end else begin : g_no_upper_chk
    assign w_upper_zero = 1'b1;
  end

  assign w_idx        = bus.PADDR[3:2];
  assign w_addr_ok    = w_upper_zero && (bus.PADDR[1:0] == 2'b00);
  // ID is read-only, so a write to it is an error even at a legal address.
  assign w_decode_err = !w_addr_ok || (bus.PWRITE && (w_idx == c_IDX_ID));

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  logic w_ready;
  logic w_wr_commit;

  // Completion happens only in the last access-phase cycle. This path is
  // combinational from the state and the bus inputs. Because the state
  // flop clears asynchronously, PREADY drops as soon as reset asserts.
  assign w_ready     = (state_q == ST_ACCESS) && bus.PSEL && bus.PENABLE &&
                       (wcnt_q == 4'd0);
  assign w_wr_commit = w_ready && bus.PWRITE && !w_decode_err;

  // --------------------------------------------------------------------------
  // Next-state / wait counter
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      ST_IDLE: begin
        // An access phase seen without a setup phase is ignored.
        if (bus.PSEL && !bus.PENABLE) begin
          state_d = ST_ACCESS;
          // The wait count is snapshotted here. A CTRL write that
          // completes later cannot stretch a transfer already running.
          wcnt_d  = ctrl_wait_q;
        end
      end
      ST_ACCESS: begin
        if (!bus.PSEL) begin
          // The requester abandoned the transfer. Nothing commits.
          state_d = ST_IDLE;
          wcnt_d  = 4'd0;
        end else if (bus.PENABLE) begin
          if (wcnt_q != 4'd0) begin
            wcnt_d = wcnt_q - 4'd1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        wcnt_d  = 4'd0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Register write path (commits only on the completion edge)
  // --------------------------------------------------------------------------
  always_comb begin
    ctrl_wait_d = ctrl_wait_q;
    scratch_d   = scratch_q;
    wr_cnt_d    = wr_cnt_q;
    if (w_wr_commit) begin
      case (w_idx)
        c_IDX_CTRL: begin
          ctrl_wait_d = bus.PWDATA[3:0];
          wr_cnt_d    = wr_cnt_q + c_ONE;
        end
        c_IDX_SCRATCH: begin
          scratch_d = bus.PWDATA;
          wr_cnt_d  = wr_cnt_q + c_ONE;
        end
        // Any write value clears the counter. The clearing write is
        // not counted.
        c_IDX_WR_CNT: begin
          wr_cnt_d = '0;
        end
        default: begin
          // ID writes are filtered out by w_decode_err.
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Read mux and response outputs
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] w_rdata;

  always_comb begin
    w_rdata = '0;
    if (w_ready && !bus.PWRITE && w_addr_ok) begin
      case (w_idx)
        c_IDX_CTRL:    w_rdata = {{(DATA_W-4){1'b0}}, ctrl_wait_q};
        c_IDX_SCRATCH: w_rdata = scratch_q;
        c_IDX_ID:      w_rdata = ID_VALUE[DATA_W-1:0];
        c_IDX_WR_CNT:  w_rdata = wr_cnt_q;
        default:       w_rdata = '0;
      endcase
    end
  end

  assign bus.PREADY  = w_ready;
  assign bus.PSLVERR = w_ready && w_decode_err;
  assign bus.PRDATA  = w_rdata;

  // --------------------------------------------------------------------------
  // Flops
  // --------------------------------------------------------------------------
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= ST_IDLE;
      wcnt_q      <= 4'd0;
      ctrl_wait_q <= 4'd0;
      scratch_q   <= '0;
      wr_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      ctrl_wait_q <= ctrl_wait_d;
      scratch_q   <= scratch_d;
      wr_cnt_q    <= wr_cnt_d;
    end
  end

endmodule : apb_slave_regs
`default_nettype wire

// File: tb/tb_apb_slave_regs.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_slave_regs
//  Purpose  : Directed self-checking bench for apb_slave_regs. Each
//             scenario task drives APB transfers and compares the results
//             with hand-computed values.
//  Ports    : none (top-level bench)
//  Revision : 1.0  initial release
// ============================================================================
module tb_apb_slave_regs;

  localparam logic [31:0] c_ID = 32'hA9B0_0001;

  logic clk;
  logic rst_n;

  int vectors;
  int miscompares;

  apb_slave_regs_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  apb_slave_regs #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .ID_VALUE (c_ID)
  ) dut (
    .PCLK    (clk),
    .PRESETn (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one complete transfer. On entry, time must be just after a
  // rising edge. On return it is just after the completion edge, with the
  // bus idle. A following call therefore issues its setup phase
  // back-to-back.
  task automatic apb_xfer(input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err,
                          output int waits);
    bit done;
    rdata = 32'h0;
    err   = 1'b0;
    waits = 0;
    done  = 1'b0;
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = wr;
    bus.PADDR   = addr;
    bus.PWDATA  = wdata;
    @(posedge clk); #1;
    bus.PENABLE = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (bus.PREADY === 1'b1) begin
        rdata = bus.PRDATA;
        err   = bus.PSLVERR;
        done  = 1'b1;
      end else begin
        waits++;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout addr=%h: PREADY never rose within 40 cycles", addr);
    end
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd, exp [4];
    logic        e;
    int          w;
    exp[0] = 32'h0; exp[1] = 32'h0; exp[2] = c_ID; exp[3] = 32'h0;
    rst_n = 1'b0;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b1; bus.PWRITE = 1'b0;
    bus.PADDR = 32'h4; bus.PWDATA = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (bus.PREADY !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_pready: got %b want 0", bus.PREADY);
    end
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      apb_xfer(1'b0, 32'(i * 4), 32'h0, rd, e, w);
      vectors++;
      if (rd !== exp[i] || e !== 1'b0 || w != 0) begin
        miscompares++;
        $display("FAIL reset_read[%0h]: got data=%h err=%b waits=%0d want data=%h err=0 waits=0",
                 i * 4, rd, e, w, exp[i]);
      end
    end
  endtask

  task automatic test_zero_wait();
    logic [31:0] rd;
    logic        e;
    int          w;
    apb_xfer(1'b1, 32'h4, 32'hDEAD_BEEF, rd, e, w);
    vectors++;
    if (e !== 1'b0 || w != 0) begin
      miscompares++;
      $display("FAIL zw_write: got err=%b waits=%0d want err=0 waits=0", e, w);
    end
    apb_xfer(1'b0, 32'h4, 32'h0, rd, e, w);
    vectors++;
    if (rd !== 32'hDEAD_BEEF || e !== 1'b0 || w != 0) begin
      miscompares++;
      $display("FAIL zw_read: got data=%h err=%b waits=%0d want deadbeef/0/0", rd, e, w);
    end
    apb_xfer(1'b0, 32'hC, 32'h0, rd, e, w);
    vectors++;
    if (rd !== 32'd1) begin
      miscompares++;
      $display("FAIL zw_wrcnt: got %h want 1", rd);
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd;
    logic        e;
    int          w;
    apb_xfer(1'b1, 32'h0, 32'h3, rd, e, w);
    vectors++;
    if (w != 0 || e !== 1'b0) begin
      miscompares++;
      $display("FAIL ws_ctrl_write: got waits=%0d err=%b want 0/0", w, e);
    end
    apb_xfer(1'b0, 32'h4, 32'h0, rd, e, w);
    vectors++;
    if (w != 3 || rd !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL ws_read: got waits=%0d data=%h want 3/deadbeef", w, rd);
    end
    apb_xfer(1'b1, 32'h0, 32'hFFFF_FFF3, rd, e, w);
    apb_xfer(1'b0, 32'h0, 32'h0, rd, e, w);
    vectors++;
    if (rd !== 32'h3 || w != 3) begin
      miscompares++;
      $display("FAIL ws_ctrl_read: got data=%h waits=%0d want 3/3", rd, w);
    end
    // The write that sets WAIT back to 0 still runs with 3 waits.
    apb_xfer(1'b1, 32'h0, 32'h0, rd, e, w);
    vectors++;
    if (w != 3) begin
      miscompares++;
      $display("FAIL ws_old_wait: got waits=%0d want 3", w);
    end
    apb_xfer(1'b0, 32'hC, 32'h0, rd, e, w);
    vectors++;
    if (rd !== 32'd4 || w != 0) begin
      miscompares++;
      $display("FAIL ws_wrcnt: got data=%h waits=%0d want 4/0", rd, w);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    logic        e;
    int          w;
    apb_xfer(1'b1, 32'h8, 32'h1234, rd, e, w);
    vectors++;
    if (e !== 1'b1) begin
      miscompares++;
      $display("FAIL err_id_write: got err=%b want 1", e);
    end
    apb_xfer(1'b1, 32'h10, 32'h5555, rd, e, w);
    vectors++;
    if (e !== 1'b1) begin
      miscompares++;
      $display("FAIL err_oob_write: got err=%b want 1", e);
    end
    apb_xfer(1'b0, 32'h5, 32'h0, rd, e, w);
    vectors++;
    if (e !== 1'b1 || rd !== 32'h0) begin
      miscompares++;
      $display("FAIL err_misaligned_read: got err=%b data=%h want 1/0", e, rd);
    end
    apb_xfer(1'b0, 32'h1000_0004, 32'h0, rd, e, w);
    vectors++;
    if (e !== 1'b1 || rd !== 32'h0) begin
      miscompares++;
      $display("FAIL err_upper_read: got err=%b data=%h want 1/0", e, rd);
    end
    apb_xfer(1'b0, 32'h8, 32'h0, rd, e, w);
    vectors++;
    if (rd !== c_ID || e !== 1'b0) begin
      miscompares++;
      $display("FAIL err_id_read: got data=%h err=%b want %h/0", rd, e, c_ID);
    end
    apb_xfer(1'b0, 32'hC, 32'h0, rd, e, w);
    vectors++;
    if (rd !== 32'd4) begin
      miscompares++;
      $display("FAIL err_wrcnt: got %h want 4", rd);
    end
  endtask

  task automatic test_counter();
    logic [31:0] rd;
    logic        e;
    int          w;
    apb_xfer(1'b1, 32'hC, 32'hFFFF_0000, rd, e, w);
    apb_xfer(1'b0, 32'hC, 32'h0, rd, e, w);
    vectors++;
    if (rd !== 32'd0) begin
      miscompares++;
      $display("FAIL cnt_clear1: got %h want 0", rd);
    end
    for (int i = 0; i < 3; i++) apb_xfer(1'b1, 32'h4, 32'(i), rd, e, w);
    apb_xfer(1'b0, 32'hC, 32'h0, rd, e, w);
    vectors++;
    if (rd !== 32'd3) begin
      miscompares++;
      $display("FAIL cnt_three: got %h want 3", rd);
    end
    apb_xfer(1'b1, 32'hC, 32'h0, rd, e, w);
    apb_xfer(1'b0, 32'hC, 32'h0, rd, e, w);
    vectors++;
    if (rd !== 32'd0) begin
      miscompares++;
      $display("FAIL cnt_clear2: got %h want 0", rd);
    end
    force dut.wr_cnt_q = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.wr_cnt_q;
    apb_xfer(1'b0, 32'hC, 32'h0, rd, e, w);
    vectors++;
    if (rd !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL cnt_backdoor: got %h want ffffffff", rd);
    end
    apb_xfer(1'b1, 32'h4, 32'h77, rd, e, w);
    apb_xfer(1'b0, 32'hC, 32'h0, rd, e, w);
    vectors++;
    if (rd !== 32'd0) begin
      miscompares++;
      $display("FAIL cnt_wrap: got %h want 0", rd);
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd;
    logic        e;
    int          w;
    // Setup phase, then PSEL drops in the first access cycle.
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
    bus.PADDR = 32'h4; bus.PWDATA = 32'h1111_2222;
    @(posedge clk); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b1;
    @(posedge clk); #1;
    bus.PENABLE = 1'b0;
    apb_xfer(1'b0, 32'h4, 32'h0, rd, e, w);
    vectors++;
    if (rd !== 32'h77) begin
      miscompares++;
      $display("FAIL abort_nowrite: got %h want 77", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic        e;
    int          w;
    apb_xfer(1'b1, 32'h4, 32'hCAFE_F00D, rd, e, w);
    apb_xfer(1'b1, 32'h0, 32'h2, rd, e, w);
    apb_xfer(1'b0, 32'h4, 32'h0, rd, e, w);
    vectors++;
    if (rd !== 32'hCAFE_F00D || w != 2) begin
      miscompares++;
      $display("FAIL b2b_read: got data=%h waits=%0d want cafef00d/2", rd, w);
    end
    apb_xfer(1'b0, 32'hC, 32'h0, rd, e, w);
    vectors++;
    if (rd !== 32'd2) begin
      miscompares++;
      $display("FAIL b2b_wrcnt: got %h want 2", rd);
    end
  endtask

  task automatic test_reset_midop();
    logic [31:0] rd;
    logic        e;
    int          w;
    apb_xfer(1'b1, 32'h0, 32'h5, rd, e, w);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
    bus.PADDR = 32'h4; bus.PWDATA = 32'h55;
    @(posedge clk); #1;
    bus.PENABLE = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.PREADY !== 1'b0 || bus.PSLVERR !== 1'b0 || bus.PRDATA !== 32'h0) begin
      miscompares++;
      $display("FAIL midop_outputs: got ready=%b err=%b data=%h want 0/0/0",
               bus.PREADY, bus.PSLVERR, bus.PRDATA);
    end
    // Hold the bus in its access phase for longer than the 5-cycle wait.
    // While reset is low, no completion may appear.
    repeat (7) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (bus.PREADY !== 1'b0) begin
      miscompares++;
      $display("FAIL midop_held: got ready=%b want 0", bus.PREADY);
    end
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    apb_xfer(1'b0, 32'h4, 32'h0, rd, e, w);
    vectors++;
    if (rd !== 32'h0 || w != 0 || e !== 1'b0) begin
      miscompares++;
      $display("FAIL midop_after: got data=%h waits=%0d err=%b want 0/0/0", rd, w, e);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
    bus.PADDR   = '0;
    bus.PWDATA  = '0;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_errors();
    test_counter();
    test_abort();
    test_back_to_back();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_apb_slave_regs
`default_nettype wire

// File: doc/apb_slave_regs.md
Name: apb_slave_regs

Overview:
APB3 completer (slave) register block: the responder end of the team's APB3 bus, connected to the slave-side signal set.
- Provides four 32-bit registers with programmable wait-state insertion and PSLVERR signalling.
- Serves as the DUT for the UVM/RAL environment: the agent drives the requester side, the RAL model mirrors this register map.

Parameters:
ADDR_W, 32, PADDR width (≥4).
DATA_W, 32, PWDATA/PRDATA width; only 32 is legal (elaboration error otherwise).
ID_VALUE, 32'hA9B0_0001, constant returned by the ID register.

Ports:
PCLK  in  1  bus clock; all state updates on rising edge.
PRESETn  in  1  reset, asynchronous assert, active low.
PSEL  in  1  select.
PENABLE  in  1  access-phase indicator.
PWRITE  in  1  1 = write, 0 = read.
PADDR  in  ADDR_W  byte address.
PWDATA  in  DATA_W  write data.
PRDATA  out  DATA_W  read data; valid only when PREADY=1 and PWRITE=0.
PREADY  out  1  transfer-complete strobe.
PSLVERR  out  1  error response; valid only when PREADY=1.

Behaviour:
- Clock and reset: one clock, PCLK. PRESETn is asynchronous, active-low. All flops clear immediately on PRESETn=0.
- Register map (full-address decode, PADDR[ADDR_W-1:4] must be 0, PADDR[1:0] must be 0):
  - 0x0 CTRL, RW, reset 0. Bits [3:0] = WAIT (0..15). Bits [31:4] read 0, writes ignored.
  - 0x4 SCRATCH, RW, reset 0. All 32 bits.
  - 0x8 ID, RO, reads ID_VALUE. A write returns an error and changes no state.
  - 0xC WR_CNT, reset 0. Counts completed, non-erroring writes to 0x0/0x4; wraps 0xFFFF_FFFF→0. Any write to 0xC clears it to 0 and is not itself counted.
  - Any other address (misaligned, ≥0x10, nonzero upper bits): error. Read returns PRDATA=0; write changes nothing.
- FSM states: IDLE, ACCESS. Reset → IDLE.
  - IDLE: if PSEL=1 and PENABLE=0 (setup phase) → ACCESS, and load wcnt ← CTRL.WAIT. Otherwise stay. PENABLE=1 seen in IDLE is ignored; PREADY stays 0.
  - ACCESS: when PSEL=1 and PENABLE=1 and wcnt≠0, decrement wcnt, stay. Completion when PSEL=1, PENABLE=1, wcnt=0 → IDLE. PSEL=0 in ACCESS → abort to IDLE, no write, no count.
- PREADY = (state==ACCESS) & PSEL & PENABLE & (wcnt==0). This is combinational from state and inputs. It is 0 in all other cycles, including during reset.
- Latency:
  - WAIT=N gives exactly N access-phase cycles with PREADY=0, then 1 cycle with PREADY=1.
  - Zero-wait transfer = 2 cycles (setup + access).
  - Back-to-back transfers are supported: completion edge → IDLE → the next setup cycle is accepted.
- PSLVERR = PREADY & decode_error. PRDATA = read mux when PREADY & !PWRITE, else 0.
- Write commit occurs on the completion edge only.
  - A write to CTRL.WAIT takes effect from the next transfer's setup phase; the current transfer's wcnt is unchanged.
  - Address and data are sampled at completion. Per APB, the master holds them stable across wait states.
- Reset mid-transfer: FSM → IDLE, wcnt=0, all registers to reset values, PREADY/PSLVERR/PRDATA=0 immediately. The pending write is discarded.

Test Plan:
1. Reset: after PRESETn release, read 0x0/0x4/0x8/0xC → 0, 0, 0xA9B0_0001, 0. Each read completes in 2 cycles with PSLVERR=0.
2. Zero-wait RW: write 0x4 ← 0xDEAD_BEEF, then read 0x4 → 0xDEAD_BEEF. WR_CNT read → 1.
3. Wait states: write CTRL ← 0x3. That write completes with 0 waits. The next read of 0x4 shows exactly 3 access cycles with PREADY=0, then PREADY=1 with correct data. CTRL read → 0x3 (upper bits 0 after writing 0xFFFF_FFF3).
4. Errors: write 0x8 ← 0x1234, write 0x10, read 0x5 → each PSLVERR=1 at PREADY. ID still reads 0xA9B0_0001, PRDATA=0 on error reads, WR_CNT unchanged.
5. Counter: 3 good writes → WR_CNT=3. Write 0xC → WR_CNT=0. Force WR_CNT=0xFFFF_FFFF (backdoor), one good write → 0.
6. Reset mid-op: CTRL.WAIT=5, start write 0x4 ← 0x55, assert PRESETn in the 2nd wait cycle. PREADY drops to 0 immediately, SCRATCH=0 after release, next transfer completes with 0 waits.
